// File: rtl/rf_seq_pkg.sv
// Shared opcodes, FSM state encoding, instruction layout and default widths
// for the register-file sequencer.
package rf_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        OUTP  = 3'd5
    } seqState_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
    } instr_t;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB with signed-overflow flag, LI
// sign extension, OUT pass-through. RF_SEQ_SAT_EN clamps ADD/SUB on overflow.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        imm,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

`ifdef RF_SEQ_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    logic [DATA_W-1:0] bEff;
    logic [DATA_W-1:0] sum;
    logic              arith;

    always_comb begin
        bEff  = (op == OP_SUB) ? (~b + DATA_W'(1)) : b;
        sum   = a + bEff;
        arith = (op == OP_ADD) || (op == OP_SUB);
        // Overflow is judged against the effective (negated for SUB) operand.
        ovf   = arith && (a[DATA_W-1] == bEff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        case (op)
            OP_ADD, OP_SUB: begin
                result = sum;
`ifdef RF_SEQ_SAT_EN
                if (ovf) result = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_LI:   result = {{(DATA_W-4){imm[3]}}, imm};
            default: result = a;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle master for the 4x8 register file: handshake, operand read,
// ALU, one-cycle write strobe. RF_SEQ_SAT_EN selects saturating ADD/SUB.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              ovf,
    output logic              busy
);

    seqState_t         state, nextState;
    instr_t            instrIn, instrQ;
    logic [1:0]        waitCnt;
    logic [DATA_W-1:0] aQ;
    logic              ovfQ;
    logic              accept;
    logic [DATA_W-1:0] aluResult;
    logic              aluOvf;
    logic              readyNext, busyNext, writeNext, outValidNext, ovfNext;

    assign instrIn = instr;
    // instr_ready is only ever high while IDLE, so this is the whole handshake.
    assign accept  = instr_valid && instr_ready;

    rf_seq_alu #(.DATA_W(DATA_W)) alu (
        .op     (instrQ.op),
        .a      (rf_read_data1),
        .b      (rf_read_data2),
        .imm    ({instrQ.rs, instrQ.rt}),
        .result (aluResult),
        .ovf    (aluOvf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (instrIn.op == OP_LI) ? EXEC : READ;
            READ:    if (waitCnt == 2'(READ_WAIT - 1)) nextState = EXEC;
            EXEC:    nextState = (instrQ.op == OP_OUT) ? OUTP : WRITE;
            WRITE:   nextState = HOLD;
            HOLD:    nextState = IDLE;
            OUTP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output values for the next cycle; every port is a flop fed from here.
    always_comb begin
        readyNext    = (state == IDLE) && !accept;
        busyNext     = (nextState != IDLE);
        writeNext    = (state == WRITE);
        outValidNext = (state == OUTP);
        ovfNext      = (state == WRITE) && ovfQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready   <= 1'b1;
            busy          <= 1'b0;
            rf_write      <= 1'b0;
            out_valid     <= 1'b0;
            ovf           <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            out_data      <= '0;
            instrQ        <= '0;
            waitCnt       <= '0;
            aQ            <= '0;
            ovfQ          <= 1'b0;
        end else begin
            instr_ready <= readyNext;
            busy        <= busyNext;
            rf_write    <= writeNext;
            out_valid   <= outValidNext;
            ovf         <= ovfNext;
            waitCnt     <= (state == READ) ? waitCnt + 2'd1 : 2'd0;
            if (accept) instrQ <= instrIn;
            if (state == READ) begin
                rf_read_reg1 <= ADDR_W'(instrQ.rs);
                rf_read_reg2 <= ADDR_W'(instrQ.rt);
            end
            // Operands are captured here, so a write to a source reg cannot disturb them.
            if (state == EXEC) begin
                aQ   <= rf_read_data1;
                ovfQ <= aluOvf;
                if (instrQ.op != OP_OUT) begin
                    rf_write_reg  <= ADDR_W'(instrQ.rd);
                    rf_write_data <= aluResult;
                end
            end
            if (state == OUTP) out_data <= aQ;
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with behavioural regfiles; one DUT with
// READ_WAIT=1 and one with READ_WAIT=3 share the instruction stimulus.
module tb_rf_sequencer;

`ifdef RF_SEQ_SAT_EN
    localparam logic [7:0] EXP_ADD_OVF = 8'h7F;
    localparam logic [7:0] EXP_SUB_OVF = 8'h80;
`else
    localparam logic [7:0] EXP_ADD_OVF = 8'h80;
    localparam logic [7:0] EXP_SUB_OVF = 8'h7F;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;

    logic       rdy1, rdy3, wr1, wr3, ov1, ov3, ovf1, ovf3, busy1, busy3;
    logic [1:0] rr1a, rr1b, rr3a, rr3b, wreg1, wreg3;
    logic [7:0] rd1a, rd1b, rd3a, rd3b, wdat1, wdat3, od1, od3;
    logic [7:0] rf1 [4];
    logic [7:0] rf3 [4];

    logic       pokeEn = 1'b0;
    logic [1:0] pokeIdx = 2'd0;
    logic [7:0] pokeVal = 8'h00;
    logic       sel3 = 1'b0;
    int         cyc = 0;
    int         nVec = 0;
    int         nBad = 0;

    logic       rdyS, wrS, ovS, ovfS, busyS;
    logic [1:0] wregS;
    logic [7:0] wdatS, odS;

    int         accN, wrAt, wrCnt, ovfAt, ovfCnt, outAt, outCnt, rdyAt;
    logic       busyAtN, stableOk;
    logic [1:0] wRegQ;
    logic [7:0] wDatQ, oDatQ;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rf_sequencer #(.DATA_W(8), .ADDR_W(2), .READ_WAIT(1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy1),
        .rf_read_reg1(rr1a), .rf_read_reg2(rr1b), .rf_read_data1(rd1a), .rf_read_data2(rd1b),
        .rf_write(wr1), .rf_write_reg(wreg1), .rf_write_data(wdat1),
        .out_data(od1), .out_valid(ov1), .ovf(ovf1), .busy(busy1)
    );

    rf_sequencer #(.DATA_W(8), .ADDR_W(2), .READ_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy3),
        .rf_read_reg1(rr3a), .rf_read_reg2(rr3b), .rf_read_data1(rd3a), .rf_read_data2(rd3b),
        .rf_write(wr3), .rf_write_reg(wreg3), .rf_write_data(wdat3),
        .out_data(od3), .out_valid(ov3), .ovf(ovf3), .busy(busy3)
    );

    // Level-sensitive regfile: a strobe held through a cycle commits at its closing edge.
    assign rd1a = rf1[rr1a];
    assign rd1b = rf1[rr1b];
    assign rd3a = rf3[rr3a];
    assign rd3b = rf3[rr3b];

    always @(posedge clk) begin
        if (pokeEn) begin
            rf1[pokeIdx] <= pokeVal;
            rf3[pokeIdx] <= pokeVal;
        end else begin
            if (wr1) rf1[wreg1] <= wdat1;
            if (wr3) rf3[wreg3] <= wdat3;
        end
    end

    always_comb begin
        rdyS  = sel3 ? rdy3  : rdy1;
        wrS   = sel3 ? wr3   : wr1;
        ovS   = sel3 ? ov3   : ov1;
        ovfS  = sel3 ? ovf3  : ovf1;
        busyS = sel3 ? busy3 : busy1;
        wregS = sel3 ? wreg3 : wreg1;
        wdatS = sel3 ? wdat3 : wdat1;
        odS   = sel3 ? od3   : od1;
    end

    task automatic poke(input logic [1:0] idx, input logic [7:0] val);
        @(negedge clk);
        pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    // Issues one instruction and records event cycles relative to the accept edge.
    task automatic runInstr(input logic [7:0] ins);
        logic [1:0] hReg [20];
        logic [7:0] hDat [20];
        int k = 0;
        accN = -100; wrAt = -1; wrCnt = 0; ovfAt = -1; ovfCnt = 0;
        outAt = -1; outCnt = 0; rdyAt = -1; stableOk = 1'b0; busyAtN = 1'b0;
        wRegQ = 2'd0; wDatQ = 8'h00; oDatQ = 8'h00;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        while (!rdyS && k < 20) begin @(negedge clk); k++; end
        accN = cyc + 1;
        @(negedge clk);
        instr_valid = 1'b0;
        busyAtN = busyS;
        for (int i = 0; i < 20; i++) begin
            hReg[i] = wregS; hDat[i] = wdatS;
            if (wrS) begin
                if (wrCnt == 0) begin wrAt = cyc; wRegQ = wregS; wDatQ = wdatS; end
                wrCnt++;
            end
            if (ovfS) begin if (ovfCnt == 0) ovfAt = cyc; ovfCnt++; end
            if (ovS) begin
                if (outCnt == 0) begin outAt = cyc; oDatQ = odS; end
                outCnt++;
            end
            if (rdyS) begin rdyAt = cyc; break; end
            @(negedge clk);
        end
        if (wrAt > accN && wrAt - accN + 1 < 20)
            stableOk = (hReg[wrAt-accN-1] == wRegQ) && (hDat[wrAt-accN-1] == wDatQ) &&
                       (hReg[wrAt-accN+1] == wRegQ) && (hDat[wrAt-accN+1] == wDatQ);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        nVec++; if (rdy1 !== 1'b1) begin nBad++; $display("FAIL reset_ready: got %b want 1", rdy1); end
        nVec++; if ({wr1, ov1, ovf1, busy1} !== 4'b0000) begin nBad++; $display("FAIL reset_flags: got %b want 0000", {wr1, ov1, ovf1, busy1}); end
        nVec++; if ({rr1a, rr1b, wreg1} !== 6'd0) begin nBad++; $display("FAIL reset_addrs: got %h want 0", {rr1a, rr1b, wreg1}); end
        nVec++; if ({wdat1, od1} !== 16'h0000) begin nBad++; $display("FAIL reset_data: got %h want 0000", {wdat1, od1}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_li;
        sel3 = 1'b0;
        runInstr(8'h95);
        nVec++; if (busyAtN !== 1'b1) begin nBad++; $display("FAIL li_busy: got %b want 1", busyAtN); end
        nVec++; if (wrAt !== accN + 2) begin nBad++; $display("FAIL li_write_cycle: got %0d want %0d", wrAt, accN + 2); end
        nVec++; if (wrCnt !== 1) begin nBad++; $display("FAIL li_strobe_len: got %0d want 1", wrCnt); end
        nVec++; if ({wRegQ, wDatQ} !== {2'd1, 8'h05}) begin nBad++; $display("FAIL li_write: got %h want 105", {wRegQ, wDatQ}); end
        nVec++; if (rdyAt !== accN + 4) begin nBad++; $display("FAIL li_ready_cycle: got %0d want %0d", rdyAt, accN + 4); end
        nVec++; if (rf1[1] !== 8'h05) begin nBad++; $display("FAIL li_regfile: got %h want 05", rf1[1]); end
    endtask

    task automatic test_add;
        sel3 = 1'b0;
        runInstr(8'hB6);
        nVec++; if ({wRegQ, wDatQ} !== {2'd2, 8'hFD}) begin nBad++; $display("FAIL li_neg: got %h want 2fd", {wRegQ, wDatQ}); end
        runInstr(8'h1B);
        nVec++; if (wrAt !== accN + 3) begin nBad++; $display("FAIL add_write_cycle: got %0d want %0d", wrAt, accN + 3); end
        nVec++; if ({wRegQ, wDatQ} !== {2'd3, 8'h02}) begin nBad++; $display("FAIL add_write: got %h want 302", {wRegQ, wDatQ}); end
        nVec++; if (wrCnt !== 1 || ovfCnt !== 0) begin nBad++; $display("FAIL add_strobe_ovf: got %0d/%0d want 1/0", wrCnt, ovfCnt); end
        nVec++; if (stableOk !== 1'b1) begin nBad++; $display("FAIL add_addr_data_stable: got %b want 1", stableOk); end
        nVec++; if (rdyAt !== accN + 5) begin nBad++; $display("FAIL add_ready_cycle: got %0d want %0d", rdyAt, accN + 5); end
        nVec++; if (rf1[3] !== 8'h02) begin nBad++; $display("FAIL add_regfile: got %h want 02", rf1[3]); end
    endtask

    task automatic test_overflow;
        sel3 = 1'b0;
        poke(2'd0, 8'h7F);
        poke(2'd1, 8'h01);
        runInstr(8'h06);
        nVec++; if ({wRegQ, wDatQ} !== {2'd2, EXP_ADD_OVF}) begin nBad++; $display("FAIL add_ovf_result: got %h want %h", {wRegQ, wDatQ}, {2'd2, EXP_ADD_OVF}); end
        nVec++; if (ovfCnt !== 1 || ovfAt !== wrAt) begin nBad++; $display("FAIL add_ovf_pulse: got cnt %0d at %0d want 1 at %0d", ovfCnt, ovfAt, wrAt); end
        poke(2'd2, 8'h80);
        runInstr(8'h64);
        nVec++; if ({wRegQ, wDatQ} !== {2'd0, EXP_SUB_OVF}) begin nBad++; $display("FAIL sub_ovf_result: got %h want %h", {wRegQ, wDatQ}, {2'd0, EXP_SUB_OVF}); end
        nVec++; if (ovfCnt !== 1 || ovfAt !== wrAt) begin nBad++; $display("FAIL sub_ovf_pulse: got cnt %0d at %0d want 1 at %0d", ovfCnt, ovfAt, wrAt); end
    endtask

    task automatic test_out;
        sel3 = 1'b0;
        runInstr(8'hF0);
        nVec++; if (outAt !== accN + 3 || outCnt !== 1) begin nBad++; $display("FAIL out_pulse: got cnt %0d at %0d want 1 at %0d", outCnt, outAt, accN + 3); end
        nVec++; if (oDatQ !== 8'h02) begin nBad++; $display("FAIL out_data: got %h want 02", oDatQ); end
        nVec++; if (wrCnt !== 0) begin nBad++; $display("FAIL out_no_write: got %0d want 0", wrCnt); end
        nVec++; if (rdyAt !== accN + 4) begin nBad++; $display("FAIL out_ready_cycle: got %0d want %0d", rdyAt, accN + 4); end
    endtask

    task automatic test_reset_mid_write;
        int k = 0;
        sel3 = 1'b0;
        poke(2'd3, 8'hAA);
        @(negedge clk);
        instr = 8'h9F; instr_valid = 1'b1;
        while (!wr1 && k < 30) begin
            if (busy1) instr_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        instr_valid = 1'b0;
        nVec++; if (wr1 !== 1'b1) begin nBad++; $display("FAIL rst_strobe_seen: got %b want 1", wr1); end
        #1 reset = 1'b1;
        #1;
        nVec++; if (wr1 !== 1'b0) begin nBad++; $display("FAIL rst_strobe_drop: got %b want 0", wr1); end
        nVec++; if ({rdy1, busy1, ov1, ovf1} !== 4'b1000) begin nBad++; $display("FAIL rst_flags: got %b want 1000", {rdy1, busy1, ov1, ovf1}); end
        nVec++; if ({wreg1, wdat1} !== 10'd0) begin nBad++; $display("FAIL rst_wdata: got %h want 0", {wreg1, wdat1}); end
        @(negedge clk);
        nVec++; if (rf1[3] !== 8'hAA) begin nBad++; $display("FAIL rst_aborted_write: got %h want aa", rf1[3]); end
        reset = 1'b0;
        runInstr(8'h9F);
        nVec++; if (wrAt !== accN + 2 || wDatQ !== 8'h07) begin nBad++; $display("FAIL rst_recover: got %h at %0d want 07 at %0d", wDatQ, wrAt, accN + 2); end
        nVec++; if (rf1[3] !== 8'h07) begin nBad++; $display("FAIL rst_recover_rf: got %h want 07", rf1[3]); end
    endtask

    // instr_valid stays high; each instruction must be taken only when the DUT is idle.
    task automatic test_back_to_back(input logic use3);
        logic [7:0] prog [4];
        int acc [4];
        int idx = 0, wr = 0, outs = 0, rw;
        logic [7:0] od = 8'h00;
        prog = '{8'h84, 8'h89, 8'h06, 8'hE0};
        acc = '{-1, -1, -1, -1};
        rw = use3 ? 3 : 1;
        sel3 = use3;
        @(negedge clk);
        instr = prog[0]; instr_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (wrS) wr++;
            if (ovS) begin outs++; od = odS; end
            if (rdyS && idx < 4) begin acc[idx] = cyc + 1; idx++; end
            @(negedge clk);
            if (idx < 4) instr = prog[idx];
            else instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        nVec++; if (idx !== 4) begin nBad++; $display("FAIL b2b_accepts rw%0d: got %0d want 4", rw, idx); end
        nVec++; if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5) begin nBad++; $display("FAIL b2b_li_gap rw%0d: got %0d,%0d want 5,5", rw, acc[1] - acc[0], acc[2] - acc[1]); end
        nVec++; if (acc[3] - acc[2] !== rw + 5) begin nBad++; $display("FAIL b2b_add_gap rw%0d: got %0d want %0d", rw, acc[3] - acc[2], rw + 5); end
        nVec++; if (wr !== 3 || outs !== 1) begin nBad++; $display("FAIL b2b_strobes rw%0d: got %0d/%0d want 3/1", rw, wr, outs); end
        nVec++; if (od !== 8'h03) begin nBad++; $display("FAIL b2b_out rw%0d: got %h want 03", rw, od); end
        nVec++; if ((use3 ? rf3[2] : rf1[2]) !== 8'h03) begin nBad++; $display("FAIL b2b_regfile rw%0d: got %h want 03", rw, use3 ? rf3[2] : rf1[2]); end
    endtask

    initial begin
        test_reset;
        test_li;
        test_add;
        test_overflow;
        test_out;
        test_reset_mid_write;
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
